// File: rtl/kiv_init_if.sv
// kiv_init_if: start/stop control, key/IV fetch and seed/map-control bundle
// between the key/IV register stage, the init controller and the map cores.
interface kiv_init_if #(parameter int KEY_W = 147, parameter int IV_W = 32);
    logic             start;
    logic             stop;
    logic [KEY_W-1:0] key_i;
    logic [IV_W-1:0]  iv_i;
    logic             read0;
    logic [19:0]      ctrl_o;
    logic [31:0]      seed_a;
    logic [30:0]      seed_b;
    logic [31:0]      seed_c;
    logic [31:0]      seed_d;
    logic             map_load;
    logic             map_step;
    logic             ks_en;
    logic             busy;
    logic             key_err;
    modport master(output start, stop, key_i, iv_i,
                   input read0, ctrl_o, seed_a, seed_b, seed_c, seed_d, map_load, map_step, ks_en, busy, key_err);
    modport slave(input start, stop, key_i, iv_i,
                  output read0, ctrl_o, seed_a, seed_b, seed_c, seed_d, map_load, map_step, ks_en, busy, key_err);
endinterface

// File: rtl/kiv_init_ctrl.sv
// kiv_init_ctrl: fetches key/IV, unpacks and IV-whitens the map seeds, loads the
// map cores, runs a fixed warm-up and then enables keystream output.
module kiv_init_ctrl #(parameter int WARMUP_CYCLES = 16) (
    input logic clk,
    input logic reset,
    kiv_init_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ, CAPT, LOAD, WARM, RUN, ERR} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [19:0] ctrl_q, ctrl_d;
    logic [31:0] seed_a_q, seed_a_d, seed_c_q, seed_c_d, seed_d_q, seed_d_d;
    logic [30:0] seed_b_q, seed_b_d;
    logic        key_err_q, key_err_d;
    logic [31:0] ka, kc, kd, iv;
    logic [30:0] kb;
    assign ka = bus.key_i[126:95];
    assign kb = bus.key_i[94:64];
    assign kc = bus.key_i[63:32];
    assign kd = bus.key_i[31:0];
    assign iv = bus.iv_i;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        seed_a_d  = seed_a_q;
        seed_b_d  = seed_b_q;
        seed_c_d  = seed_c_q;
        seed_d_d  = seed_d_q;
        key_err_d = key_err_q;
        // stop overrides everything, including a simultaneous start
        if (bus.stop) state_d = IDLE;
        else begin
            case (state_q)
                IDLE: state_d = bus.start ? REQ : IDLE;
                REQ:  state_d = CAPT;
                CAPT: begin
                    if (~|{ka, kb, kc, kd}) begin
                        key_err_d = 1'b1;
                        state_d   = ERR;
                    end else begin
                        ctrl_d    = bus.key_i[146:127];
                        seed_a_d  = ka ^ iv;
                        seed_b_d  = kb ^ iv[30:0];
                        seed_c_d  = kc ^ {iv[15:0], iv[31:16]};
                        seed_d_d  = kd ^ ~iv;
                        key_err_d = 1'b0;
                        state_d   = LOAD;
                    end
                end
                LOAD: begin
                    cnt_d   = '0;
                    state_d = WARM;
                end
                WARM: begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = (cnt_q == 8'(WARMUP_CYCLES - 1)) ? RUN : WARM;
                end
                RUN:     state_d = bus.start ? REQ : RUN;
                ERR:     state_d = bus.start ? REQ : ERR;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            seed_a_q  <= '0;
            seed_b_q  <= '0;
            seed_c_q  <= '0;
            seed_d_q  <= '0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            seed_a_q  <= seed_a_d;
            seed_b_q  <= seed_b_d;
            seed_c_q  <= seed_c_d;
            seed_d_q  <= seed_d_d;
            key_err_q <= key_err_d;
        end
    end
    assign bus.read0    = state_q == REQ;
    assign bus.map_load = state_q == LOAD;
    assign bus.map_step = state_q == WARM || state_q == RUN;
    assign bus.ks_en    = state_q == RUN;
    assign bus.busy     = state_q == REQ || state_q == CAPT || state_q == LOAD || state_q == WARM;
    assign bus.ctrl_o   = ctrl_q;
    assign bus.seed_a   = seed_a_q;
    assign bus.seed_b   = seed_b_q;
    assign bus.seed_c   = seed_c_q;
    assign bus.seed_d   = seed_d_q;
    assign bus.key_err  = key_err_q;
endmodule

// File: tb/tb_kiv_init_ctrl.sv
// tb_kiv_init_ctrl: directed sequence with random keys/IVs, checked against a
// schedule-and-field model derived from the controller's documented behaviour.
module tb_kiv_init_ctrl;
    localparam int W = 16;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    kiv_init_if bus();
    kiv_init_ctrl #(.WARMUP_CYCLES(W)) dut(.clk(clk), .reset(reset), .bus(bus));
    int checks = 0;
    int errors = 0;
    logic [19:0] want_ctrl;
    logic [31:0] want_a, want_c, want_d;
    logic [30:0] want_b;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Expected seeds/fields: pure shift-and-mask arithmetic on the whole key
    task automatic model(input logic [146:0] key, input logic [31:0] iv);
        want_ctrl = 20'(key >> 127);
        want_a    = 32'(key >> 95) ^ iv;
        want_b    = 31'(key >> 64) ^ 31'(iv);
        want_c    = 32'(key >> 32) ^ ((iv << 16) | (iv >> 16));
        want_d    = 32'(key) ^ ~iv;
    endtask
    task automatic chk_data(input string tag);
        chk({tag, "_ctrl"}, 64'(bus.ctrl_o), 64'(want_ctrl));
        chk({tag, "_seed_a"}, 64'(bus.seed_a), 64'(want_a));
        chk({tag, "_seed_b"}, 64'(bus.seed_b), 64'(want_b));
        chk({tag, "_seed_c"}, 64'(bus.seed_c), 64'(want_c));
        chk({tag, "_seed_d"}, 64'(bus.seed_d), 64'(want_d));
    endtask
    task automatic chk_strobes(input string tag, input logic r, input logic l, input logic s, input logic k, input logic b);
        chk({tag, "_read0"}, 64'(bus.read0), 64'(r));
        chk({tag, "_map_load"}, 64'(bus.map_load), 64'(l));
        chk({tag, "_map_step"}, 64'(bus.map_step), 64'(s));
        chk({tag, "_ks_en"}, 64'(bus.ks_en), 64'(k));
        chk({tag, "_busy"}, 64'(bus.busy), 64'(b));
    endtask
    function automatic logic [146:0] rand_key();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[146:0];
    endfunction
    // Start pulse, then walk the whole schedule by offset from the sampling edge
    task automatic run_seq(input string tag, input logic [146:0] key, input logic [31:0] iv, input int glitch);
        bus.key_i = key;
        bus.iv_i  = iv;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k <= W + 4; k++) begin
            chk_strobes(tag, k == 0, k == 2, k >= 3, k >= 3 + W, k < 3 + W);
            if (k == 2) begin
                model(key, iv);
                chk({tag, "_key_err"}, 64'(bus.key_err), 64'd0);
                chk_data(tag);
            end
            if (k == glitch) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
    endtask
    initial begin
        logic [146:0] key;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.key_i = '0;
        bus.iv_i  = '0;
        want_ctrl = '0; want_a = '0; want_b = '0; want_c = '0; want_d = '0;
        #12;
        chk_strobes("reset", 0, 0, 0, 0, 0);
        chk_data("reset");
        chk("reset_key_err", 64'(bus.key_err), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        chk_strobes("idle", 0, 0, 0, 0, 0);
        run_seq("vec", {5'b00011, 5'b11000, 5'b01100, 5'b01100, 32'hF0AA5294, 31'h61E49987,
                        32'hFC0330C5, 32'hE40330F1}, 32'hC33CB332, -1);
        chk("vec_seed_a_const", 64'(bus.seed_a), 64'h3396E1A6);
        chk("vec_ctrl_const", 64'(bus.ctrl_o), 64'h1E18C);
        // all-zero seed fields: error path keeps previous seeds
        key = rand_key();
        bus.key_i = {key[146:127], 127'b0};
        bus.iv_i  = $urandom;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_strobes("zk0", 1, 0, 0, 0, 1);
        tick();
        chk_strobes("zk1", 0, 0, 0, 0, 1);
        for (int k = 2; k < 6; k++) begin
            tick();
            chk_strobes("zk_err", 0, 0, 0, 0, 0);
            chk("zk_key_err", 64'(bus.key_err), 64'd1);
        end
        chk_data("zk_hold");
        run_seq("recover", rand_key(), $urandom, -1);
        // start and stop together in RUN: stop wins
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk_strobes("stop0", 0, 0, 0, 0, 0);
        tick();
        chk_strobes("stop1", 0, 0, 0, 0, 0);
        chk_data("stop_hold");
        run_seq("restart", rand_key(), $urandom, -1);
        run_seq("glitch", rand_key(), $urandom, 3 + int'($urandom_range(0, W - 1)));
        run_seq("rekey", rand_key(), $urandom, -1);
        // async reset mid-warm-up with counter at 7
        bus.key_i = rand_key();
        bus.iv_i  = $urandom;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        chk_strobes("warm7", 0, 0, 1, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        want_ctrl = '0; want_a = '0; want_b = '0; want_c = '0; want_d = '0;
        chk_strobes("async", 0, 0, 0, 0, 0);
        chk_data("async");
        chk("async_key_err", 64'(bus.key_err), 64'd0);
        tick();
        #2;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_strobes("post_rst", 0, 0, 0, 0, 0);
        end
        run_seq("final", rand_key(), $urandom, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
